pipeline_hazard_ctrl: RTL and testbench

Hazard controller for the five-stage SimpleRISC pipeline (IF, OF/ID, EX, MA, RW). It sits beside the instruction decoder and takes that decoder's register fields for the instruction in ID. It keeps a shadow scoreboard of the instructions in EX, MA and RW, and from it generates stall, bubble and flush controls plus registered operand-forwarding selects for EX. It also sequences the multi-cycle mul/div/mod unit by holding EX for a parameterised number of cycles.

---
 rtl/simplerisc_pkg.sv | 106 ++++++++++
 rtl/mdu_seq.sv | 47 ++++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions for the hazard controller: opcodes, forward
// selects, the shadow-scoreboard entry and the ID-stage register-use decoder.
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    // EX operand selects: register file, EX/MA result, MA/RW result
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_MA = 2'd1;
    localparam logic [1:0] FWD_RW = 2'd2;

    localparam logic [3:0] RA_REG = 4'd15;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [3:0] rd;
        logic       is_load;
        logic       is_mdu;
    } sb_entry_t;

    // Register usage of the instruction in ID; operand A is rs1 (or ra for
    // ret), operand B is rs2 (the stored value for st)
    typedef struct packed {
        logic       rd_a;
        logic [3:0] src_a;
        logic       rd_b;
        logic [3:0] src_b;
        sb_entry_t  ent;
    } id_dec_t;

    typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} mdu_state_t;

    function automatic id_dec_t decode_id(input logic [4:0] op, input logic imm,
                                          input logic [3:0] rs1, input logic [3:0] rs2,
                                          input logic [3:0] rd);
        id_dec_t d;
        d           = '0;
        d.src_a     = rs1;
        d.src_b     = rs2;
        d.ent.valid = 1'b1;
        d.ent.rd    = rd;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR: begin
                d.rd_a   = 1'b1;
                d.rd_b   = !imm;
                d.ent.wr = 1'b1;
            end
            OP_MUL, OP_DIV, OP_MOD: begin
                d.rd_a       = 1'b1;
                d.rd_b       = !imm;
                d.ent.wr     = 1'b1;
                d.ent.is_mdu = 1'b1;
            end
            OP_NOT, OP_MOV: begin
                d.rd_b   = !imm;
                d.ent.wr = 1'b1;
            end
            OP_CMP: begin
                d.rd_a = 1'b1;
                d.rd_b = !imm;
            end
            OP_LD: begin
                d.rd_a        = 1'b1;
                d.ent.wr      = 1'b1;
                d.ent.is_load = 1'b1;
            end
            OP_ST: begin
                d.rd_a = 1'b1;
                d.rd_b = 1'b1;
            end
            OP_CALL: begin
                d.ent.wr = 1'b1;
                d.ent.rd = RA_REG;
            end
            OP_RET: begin
                d.rd_a  = 1'b1;
                d.src_a = RA_REG;
            end
            OP_B, OP_BEQ, OP_BGT, OP_NOP: ;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle mul/div/mod sequencer: RUN/MDU_BUSY state machine with a
// down-counter that keeps EX frozen until the op has spent its full latency.
module mdu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cycles,
    output logic       busy
);
    import simplerisc_pkg::*;

    mdu_state_t r_state;
    logic [3:0] r_cnt;
    logic       r_busy;

    // Enter MDU_BUSY for cycles-1 extra EX cycles; the final EX cycle runs in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (start && (cycles > 4'd1)) begin
                        r_state <= MDU_BUSY;
                        r_cnt   <= cycles - 4'd1;
                        r_busy  <= 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the five-stage SimpleRISC pipeline. Tracks EX/MA/RW
// in a shadow scoreboard and drives stall/bubble/hold/flush plus registered
// EX forward selects. Build option HAZARD_FWD_EN enables forwarding; without
// it the block interlocks on every EX/MA dependence and selects stay 0.
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_opcode,
    input  logic       id_imm,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic [3:0] id_rd,
    input  logic       ex_branch_taken,
    output logic       stall_if,
    output logic       bubble_ex,
    output logic       hold_ex,
    output logic       flush,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);
    import simplerisc_pkg::*;

    localparam logic [3:0] MUL_C = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_C = 4'(DIV_CYCLES);

    id_dec_t    w_dec;
    sb_entry_t  r_ex, r_ma, r_rw;
    logic       w_a_ex, w_a_ma, w_b_ex, w_b_ma;
    logic       w_haz, w_busy, w_kill, w_start;
    logic [3:0] w_cycles;
    logic       w_unused;

    function automatic logic hits(input logic [3:0] src, input sb_entry_t e);
        return e.valid && e.wr && (e.rd == src);
    endfunction

    assign w_dec  = decode_id(id_opcode, id_imm, id_rs1, id_rs2, id_rd);
    assign w_a_ex = w_dec.rd_a && hits(w_dec.src_a, r_ex);
    assign w_a_ma = w_dec.rd_a && hits(w_dec.src_a, r_ma);
    assign w_b_ex = w_dec.rd_b && hits(w_dec.src_b, r_ex);
    assign w_b_ma = w_dec.rd_b && hits(w_dec.src_b, r_ma);

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time
    assign w_haz = id_valid && r_ex.is_load && (w_a_ex || w_b_ex);
`else
    // Interlock until every producer has reached RW
    assign w_haz = id_valid && (w_a_ex || w_a_ma || w_b_ex || w_b_ma);
`endif

    // Priority: flush, then multi-cycle hold, then data hazard
    assign flush     = ex_branch_taken;
    assign hold_ex   = w_busy && !flush;
    assign stall_if  = !flush && (w_busy || w_haz);
    assign bubble_ex = !flush && !w_busy && w_haz;

    // ID contents that must not enter EX this cycle
    assign w_kill   = flush || bubble_ex || !id_valid;
    assign w_start  = !hold_ex && !w_kill && w_dec.ent.is_mdu;
    assign w_cycles = (id_opcode == OP_MUL) ? MUL_C : DIV_C;

    mdu_seq u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .cycles (w_cycles),
        .busy   (w_busy)
    );

    // Shadow scoreboard: advance EX->MA->RW unless EX is frozen
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex <= '0;
            r_ma <= '0;
            r_rw <= '0;
        end else if (!hold_ex) begin
            r_rw <= r_ma;
            r_ma <= r_ex;
            r_ex <= w_kill ? '0 : w_dec.ent;
        end
    end

`ifdef HAZARD_FWD_EN
    logic [1:0] r_fwd_a, r_fwd_b;

    // Younger producer in EX wins over MA
    function automatic logic [1:0] pick(input logic hit_ex, input logic hit_ma);
        return hit_ex ? FWD_MA : (hit_ma ? FWD_RW : FWD_RF);
    endfunction

    // Forward selects registered alongside the instruction entering EX
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (flush) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (!hold_ex) begin
            if (w_kill) begin
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end else begin
                r_fwd_a <= pick(w_a_ex, w_a_ma);
                r_fwd_b <= pick(w_b_ex, w_b_ma);
            end
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    // RW entry completes the shadow pipeline but the write-first register
    // file means nothing needs to compare against it
    assign w_unused = ^{r_rw, r_ma.is_load, r_ma.is_mdu, r_ex.is_mdu, r_ex.is_load};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized instruction streams, checked against a stage-occupancy model.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    localparam int MULC = 2;
    localparam int DIVC = 8;

    localparam int T_ADD = 0,  T_SUB = 1,  T_MUL = 2,  T_DIV = 3,  T_MOD = 4;
    localparam int T_CMP = 5,  T_AND = 6,  T_OR = 7,   T_NOT = 8,  T_MOV = 9;
    localparam int T_LSL = 10, T_LSR = 11, T_ASR = 12, T_NOP = 13, T_LD = 14;
    localparam int T_ST = 15,  T_CALL = 19, T_RET = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_opcode = '0;
    logic       id_imm = 1'b0;
    logic [3:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       ex_branch_taken = 1'b0;
    logic       stall_if, bubble_ex, hold_ex, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .stall_if        (stall_if),
        .bubble_ex       (bubble_ex),
        .hold_ex         (hold_ex),
        .flush           (flush),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instruction occupying EX and MA, plus the number
    // of EX cycles the EX instruction still has to spend there
    typedef struct packed {
        bit       v;
        bit       wr;
        bit [3:0] rd;
        bit       ld;
        bit [1:0] fa;
        bit [1:0] fb;
    } minst_t;

    minst_t m_ex = '0, m_ma = '0, n_ent = '0;
    int     m_left = 0, n_lat = 1;
    bit     e_flush, e_stall, e_bubble, e_hold;

    function automatic void tb_decode(input int op, input bit imm, input bit [3:0] s1,
                                      input bit [3:0] s2, input bit [3:0] d,
                                      output bit ua, output bit [3:0] sa,
                                      output bit ub, output bit [3:0] sb,
                                      output bit wr, output bit [3:0] wd,
                                      output bit ld, output int lat);
        ua = 0; ub = 0; wr = 0; ld = 0; sa = s1; sb = s2; wd = d; lat = 1;
        if (op inside {T_ADD, T_SUB, T_MUL, T_DIV, T_MOD, T_AND, T_OR, T_LSL, T_LSR, T_ASR}) begin
            ua = 1; ub = !imm; wr = 1;
        end else if (op inside {T_NOT, T_MOV}) begin
            ub = !imm; wr = 1;
        end else if (op == T_CMP) begin
            ua = 1; ub = !imm;
        end else if (op == T_LD) begin
            ua = 1; wr = 1; ld = 1;
        end else if (op == T_ST) begin
            ua = 1; ub = 1;
        end else if (op == T_CALL) begin
            wr = 1; wd = 4'd15;
        end else if (op == T_RET) begin
            ua = 1; sa = 4'd15;
        end
        if (op == T_MUL) lat = MULC;
        else if (op == T_DIV || op == T_MOD) lat = DIVC;
    endfunction

    function automatic bit in_stage(input minst_t e, input bit [3:0] r);
        return e.v && e.wr && (e.rd == r);
    endfunction

    task automatic recompute();
        bit ua, ub, wr, ld, busy, aex, ama, bex, bma, haz;
        bit [3:0] sa, sb, wd;
        int lat;
        tb_decode(int'(id_opcode), id_imm, id_rs1, id_rs2, id_rd, ua, sa, ub, sb, wr, wd, ld, lat);
        busy = m_ex.v && (m_left > 1);
        aex = ua && in_stage(m_ex, sa);
        ama = ua && in_stage(m_ma, sa);
        bex = ub && in_stage(m_ex, sb);
        bma = ub && in_stage(m_ma, sb);
        if (FWD_EN) haz = id_valid && m_ex.ld && (aex || bex);
        else        haz = id_valid && (aex || ama || bex || bma);
        e_flush  = ex_branch_taken;
        e_hold   = !e_flush && busy;
        e_stall  = !e_flush && (busy || haz);
        e_bubble = !e_flush && !busy && haz;
        n_ent    = '0;
        n_ent.v  = 1; n_ent.wr = wr; n_ent.rd = wd; n_ent.ld = ld;
        n_ent.fa = (FWD_EN && ua) ? (aex ? 2'd1 : (ama ? 2'd2 : 2'd0)) : 2'd0;
        n_ent.fb = (FWD_EN && ub) ? (bex ? 2'd1 : (bma ? 2'd2 : 2'd0)) : 2'd0;
        n_lat    = lat;
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_ex = '0; m_ma = '0; m_left = 0;
        end else if (e_hold) begin
            m_left--;
        end else begin
            m_ma = m_ex;
            if (e_flush || e_bubble || !id_valid) begin
                m_ex = '0; m_left = 0;
            end else begin
                m_ex = n_ent; m_left = n_lat;
            end
        end
    endtask

    task automatic chk_all();
        chk("flush",     32'(flush),     32'(e_flush));
        chk("stall_if",  32'(stall_if),  32'(e_stall));
        chk("bubble_ex", 32'(bubble_ex), 32'(e_bubble));
        chk("hold_ex",   32'(hold_ex),   32'(e_hold));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(m_ex.fa));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(m_ex.fb));
    endtask

    task automatic drv(input bit v, input int op, input bit imm, input int s1,
                       input int s2, input int d, input bit br);
        id_valid = v; id_opcode = 5'(op); id_imm = imm;
        id_rs1 = 4'(s1); id_rs2 = 4'(s2); id_rd = 4'(d); ex_branch_taken = br;
    endtask

    task automatic settle();
        @(negedge clk);
        recompute();
        chk_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        drv(0, T_NOP, 0, 0, 0, 0, 0);
        repeat (n) begin settle(); adv(); end
    endtask

    // Present one instruction in ID and keep it there while the DUT stalls
    task automatic issue(input int op, input bit imm, input int s1, input int s2, input int d,
                         output int stalls, output int holds, output bit b0);
        bit st, done;
        stalls = 0; holds = 0; b0 = 0; done = 0;
        drv(1, op, imm, s1, s2, d, 0);
        for (int k = 0; k < 40; k++) begin
            settle();
            if (k == 0) b0 = bubble_ex;
            st = stall_if;
            if (hold_ex === 1'b1) holds++;
            adv();
            if (st !== 1'b1) begin done = 1; break; end
            stalls++;
        end
        chk("issue_done", 32'(done), 32'd1);
    endtask

    function automatic int rreg();
        int k = $urandom_range(9, 0);
        return (k >= 8) ? 15 : (k % 4);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, h;
        bit b0, keep, killed;
        int r_op, r_s1, r_s2, r_d;
        bit r_v, r_imm, r_br;

        // Reset and reset-state outputs
        drv(0, T_NOP, 0, 0, 0, 0, 0);
        rst = 1'b0;
        adv(); adv();
        rst = 1'b1;
        settle();
        chk("rst_stall", 32'(stall_if), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        adv();

        // add r1 then sub using r1
        issue(T_ADD, 0, 5, 6, 1, s, h, b0);
        issue(T_SUB, 0, 1, 3, 2, s, h, b0);
        chk("addsub_stalls", s, FWD_EN ? 0 : 2);
        drv(0, T_NOP, 0, 0, 0, 0, 0);
        settle();
        chk("addsub_fwd_a", 32'(fwd_a_sel), FWD_EN ? 1 : 0);
        adv();

        // load-use
        idle(3);
        issue(T_LD, 0, 7, 0, 3, s, h, b0);
        issue(T_ADD, 0, 3, 8, 9, s, h, b0);
        chk("lduse_stalls", s, FWD_EN ? 1 : 2);
        chk("lduse_bubble", 32'(b0), 32'd1);
        drv(0, T_NOP, 0, 0, 0, 0, 0);
        settle();
        chk("lduse_fwd_a", 32'(fwd_a_sel), FWD_EN ? 2 : 0);
        adv();

        // div then add, mul then add
        idle(3);
        issue(T_DIV, 0, 1, 2, 10, s, h, b0);
        issue(T_ADD, 0, 4, 5, 6, s, h, b0);
        chk("div_hold", h, DIVC - 1);
        chk("div_stall", s, DIVC - 1);
        idle(3);
        issue(T_MUL, 0, 1, 2, 11, s, h, b0);
        issue(T_ADD, 0, 4, 5, 6, s, h, b0);
        chk("mul_hold", h, MULC - 1);

        // taken branch beats load-use
        idle(3);
        issue(T_LD, 0, 7, 0, 3, s, h, b0);
        drv(1, T_ADD, 0, 3, 8, 9, 1);
        settle();
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_stall", 32'(stall_if), 32'd0);
        chk("br_bubble", 32'(bubble_ex), 32'd0);
        adv();
        drv(0, T_NOP, 0, 0, 0, 0, 0);
        settle();
        chk("br_fwd_a", 32'(fwd_a_sel), 32'd0);
        adv();

        // call then ret; mov with immediate
        idle(3);
        issue(T_CALL, 0, 0, 0, 0, s, h, b0);
        issue(T_RET, 0, 2, 3, 4, s, h, b0);
        chk("ret_stalls", s, FWD_EN ? 0 : 2);
        drv(0, T_NOP, 0, 0, 0, 0, 0);
        settle();
        chk("ret_fwd_a", 32'(fwd_a_sel), FWD_EN ? 1 : 0);
        adv();
        idle(3);
        issue(T_ADD, 0, 5, 6, 1, s, h, b0);
        issue(T_MOV, 1, 1, 1, 4, s, h, b0);
        chk("mov_imm_stalls", s, 0);

        // invalid ID never stalls
        idle(3);
        issue(T_LD, 0, 7, 0, 3, s, h, b0);
        drv(0, T_ADD, 0, 3, 3, 5, 0);
        settle();
        chk("invalid_nostall", 32'(stall_if), 32'd0);
        adv();

        // reset during MDU_BUSY
        idle(3);
        issue(T_DIV, 0, 1, 2, 12, s, h, b0);
        drv(0, T_NOP, 0, 0, 0, 0, 0);
        settle();
        chk("mdu_busy_hold", 32'(hold_ex), 32'd1);
        adv();
        rst = 1'b0;
        adv();
        rst = 1'b1;
        settle();
        chk("mdurst_hold", 32'(hold_ex), 32'd0);
        chk("mdurst_stall", 32'(stall_if), 32'd0);
        adv();

        // randomized instruction stream
        keep = 0; killed = 0;
        r_v = 0; r_op = T_NOP; r_imm = 0; r_s1 = 0; r_s2 = 0; r_d = 0;
        for (int i = 0; i < 1500; i++) begin
            if ((i % 250) == 249) begin
                drv(0, T_NOP, 0, 0, 0, 0, 0);
                rst = 1'b0;
                adv();
                rst = 1'b1;
                keep = 0; killed = 0;
                continue;
            end
            if (!keep) begin
                r_v   = killed ? 1'b0 : ($urandom_range(9, 0) != 0);
                r_op  = $urandom_range(20, 0);
                r_imm = $urandom_range(1, 0) == 1;
                r_s1  = rreg(); r_s2 = rreg(); r_d = rreg();
            end
            r_br = !(m_ex.v && (m_left > 1)) && ($urandom_range(11, 0) == 0);
            drv(r_v, r_op, r_imm, r_s1, r_s2, r_d, r_br);
            settle();
            keep   = e_stall;
            killed = e_flush;
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
